// File: rtl/mtm_alu_ctrl.sv
// mtm_alu_ctrl: sequences one mtm_Alu serial transaction.
// Accepts a parallel request (A, B, OP), serializes eight data frames and one
// cmd frame (with CRC4) onto sin, then collects the response frames from sout
// and reports result, control byte and status on a one-cycle valid pulse.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   i_req_valid/o_req_ready request handshake
//   i_req_a/i_req_b/i_req_op operands and opcode
//   o_sin / i_sout          serial lines to/from the ALU
//   o_rsp_valid             one-cycle response pulse
//   o_rsp_c/o_rsp_ctl/o_rsp_status  response payload, held until next pulse
module mtm_alu_ctrl #(
    parameter int unsigned GAP_CYCLES  = 5,
    parameter int unsigned RSP_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_a,
    input  logic [31:0] i_req_b,
    input  logic [2:0]  i_req_op,
    output logic        o_sin,
    input  logic        i_sout,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_c,
    output logic [7:0]  o_rsp_ctl,
    output logic [1:0]  o_rsp_status
);

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned OP_W       = 3;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned MSG_W      = 2 * DATA_W + BYTE_W;
    localparam int unsigned FRAME_LAST = 10;
    localparam int unsigned SLOT_LAST  = FRAME_LAST + GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(SLOT_LAST + 1);
    localparam int unsigned TMO_W      = $clog2(RSP_TIMEOUT + 2);
    localparam int unsigned FRAME_W    = 4;
    localparam int unsigned TX_LAST    = 8;
    localparam int unsigned RX_CMD_IDX = 4;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ALU_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_FRAMING = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_TX, S_RX_HUNT, S_RX_FRAME, S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_a, r_b, r_c_acc, w_c_acc_nxt;
    logic [OP_W-1:0]     r_op;
    logic [CNT_W-1:0]    r_bit_cnt, w_cnt_nxt;
    logic [FRAME_W-1:0]  r_frame, w_frame_nxt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
    logic                r_rx_type, w_rx_type_nxt;
    logic [BYTE_W-1:0]   r_rx_sh, w_rx_sh_nxt;
    logic [1:0]          w_end_status;
    logic [BYTE_W-1:0]   w_end_ctl;
    logic [DATA_W-1:0]   w_end_c;

    logic                r_sin, r_req_ready, r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_c;
    logic [BYTE_W-1:0]   r_rsp_ctl;
    logic [1:0]          r_rsp_status;
    logic                w_sin_nxt;
    logic [DATA_W-1:0]   w_a_src, w_b_src;
    logic [OP_W-1:0]     w_op_src;
    logic [MSG_W-1:0]    w_tx_msg, w_tx_shift;
    logic [BYTE_W-1:0]   w_tx_byte;
    logic [2:0]          w_bit_idx;

    // CRC4 over x^4+x+1, fed MSB first
    function automatic logic [3:0] crc4(input logic [MSG_W-1:0] msg);
        logic [3:0] r;
        r = '0;
        for (int i = MSG_W - 1; i >= 0; i--) begin
            r = {r[2], r[1], r[3] ^ r[0], r[3] ^ msg[i]};
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and datapath-next logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_bit_cnt;
        w_frame_nxt   = r_frame;
        w_tmo_nxt     = r_tmo;
        w_rx_type_nxt = r_rx_type;
        w_rx_sh_nxt   = r_rx_sh;
        w_c_acc_nxt   = r_c_acc;
        w_end_status  = ST_FRAMING;
        w_end_ctl     = '0;
        w_end_c       = r_c_acc;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_state_nxt = S_TX;
                    w_cnt_nxt   = '0;
                    w_frame_nxt = '0;
                    w_c_acc_nxt = '0;
                end
            end
            S_TX: begin
                // No gap after the last stop bit
                if (r_bit_cnt == CNT_W'(FRAME_LAST) && r_frame == FRAME_W'(TX_LAST)) begin
                    w_state_nxt = S_RX_HUNT;
                    w_frame_nxt = '0;
                    w_tmo_nxt   = TMO_W'(RSP_TIMEOUT);
                end else if (r_bit_cnt == CNT_W'(SLOT_LAST)) begin
                    w_cnt_nxt   = '0;
                    w_frame_nxt = r_frame + FRAME_W'(1);
                end else begin
                    w_cnt_nxt = r_bit_cnt + CNT_W'(1);
                end
            end
            S_RX_HUNT: begin
                if (!i_sout) begin
                    w_state_nxt = S_RX_FRAME;
                    w_cnt_nxt   = '0;
                end else if (r_tmo <= TMO_W'(1)) begin
                    w_state_nxt  = S_DONE;
                    w_end_status = ST_TIMEOUT;
                end else begin
                    w_tmo_nxt = r_tmo - TMO_W'(1);
                end
            end
            S_RX_FRAME: begin
                w_cnt_nxt = r_bit_cnt + CNT_W'(1);
                if (r_bit_cnt == CNT_W'(0)) begin
                    w_rx_type_nxt = i_sout;
                end else if (r_bit_cnt < CNT_W'(9)) begin
                    w_rx_sh_nxt = {r_rx_sh[BYTE_W-2:0], i_sout};
                end else begin
                    // Stop bit: classify the completed frame
                    w_state_nxt = S_DONE;
                    if (!i_sout) begin
                        w_end_status = ST_FRAMING;
                    end else if (r_rx_type && r_frame == FRAME_W'(0)) begin
                        w_end_status = ST_ALU_ERR;
                        w_end_ctl    = r_rx_sh;
                        w_end_c      = '0;
                    end else if (!r_rx_type && r_frame < FRAME_W'(RX_CMD_IDX)) begin
                        w_state_nxt = S_RX_HUNT;
                        w_c_acc_nxt = {r_c_acc[DATA_W-BYTE_W-1:0], r_rx_sh};
                        w_frame_nxt = r_frame + FRAME_W'(1);
                        w_tmo_nxt   = TMO_W'(RSP_TIMEOUT);
                    end else if (r_rx_type && r_frame == FRAME_W'(RX_CMD_IDX)) begin
                        w_end_status = ST_OK;
                        w_end_ctl    = r_rx_sh;
                    end else begin
                        w_end_status = ST_FRAMING;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_a_src    = (r_state == S_IDLE) ? i_req_a  : r_a;
        w_b_src    = (r_state == S_IDLE) ? i_req_b  : r_b;
        w_op_src   = (r_state == S_IDLE) ? i_req_op : r_op;
        w_tx_msg   = {w_b_src, w_a_src, 1'b1, w_op_src,
                      crc4({w_b_src, w_a_src, 1'b1, w_op_src, 4'b0000})};
        w_tx_shift = w_tx_msg << {w_frame_nxt, 3'b000};
        w_tx_byte  = w_tx_shift[MSG_W-1 -: BYTE_W];
        w_bit_idx  = 3'(CNT_W'(9) - w_cnt_nxt);
        w_sin_nxt  = 1'b1;
        if (w_state_nxt == S_TX && w_cnt_nxt <= CNT_W'(FRAME_LAST)) begin
            if (w_cnt_nxt == CNT_W'(0))              w_sin_nxt = 1'b0;
            else if (w_cnt_nxt == CNT_W'(1))         w_sin_nxt = (w_frame_nxt == FRAME_W'(TX_LAST));
            else if (w_cnt_nxt == CNT_W'(FRAME_LAST)) w_sin_nxt = 1'b1;
            else                                     w_sin_nxt = w_tx_byte[w_bit_idx];
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_bit_cnt <= '0;
            r_frame   <= '0;
            r_tmo     <= '0;
            r_rx_type <= 1'b0;
            r_rx_sh   <= '0;
            r_c_acc   <= '0;
        end else begin
            if (r_state == S_IDLE && i_req_valid) begin
                r_a  <= i_req_a;
                r_b  <= i_req_b;
                r_op <= i_req_op;
            end
            r_bit_cnt <= w_cnt_nxt;
            r_frame   <= w_frame_nxt;
            r_tmo     <= w_tmo_nxt;
            r_rx_type <= w_rx_type_nxt;
            r_rx_sh   <= w_rx_sh_nxt;
            r_c_acc   <= w_c_acc_nxt;
        end
    end

    // Output registers; response fields only change when a pulse is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sin        <= 1'b1;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_c      <= '0;
            r_rsp_ctl    <= '0;
            r_rsp_status <= ST_OK;
        end else begin
            r_sin       <= w_sin_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) begin
                r_rsp_c      <= w_end_c;
                r_rsp_ctl    <= w_end_ctl;
                r_rsp_status <= w_end_status;
            end
        end
    end

    assign o_sin        = r_sin;
    assign o_req_ready  = r_req_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_c      = r_rsp_c;
    assign o_rsp_ctl    = r_rsp_ctl;
    assign o_rsp_status = r_rsp_status;

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// tb_mtm_alu_ctrl: bench for mtm_alu_ctrl; plays the ALU on sout and checks
// the serialized request and the reported response against a reference model.
module tb_mtm_alu_ctrl;

    localparam int unsigned GAP    = 5;
    localparam int unsigned TMO    = 50;
    localparam int unsigned TX_LEN = 9 * 11 + 8 * GAP;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam int MODE_OK      = 0;
    localparam int MODE_ALU_ERR = 1;
    localparam int MODE_TIMEOUT = 2;
    localparam int MODE_STOPERR = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a, req_b;
    logic [2:0]  req_op;
    logic        sin, sout;
    logic        rsp_valid;
    logic [31:0] rsp_c;
    logic [7:0]  rsp_ctl;
    logic [1:0]  rsp_status;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_c;
    bit          have_last;

    always #5 clk = ~clk;

    mtm_alu_ctrl #(.GAP_CYCLES(GAP), .RSP_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_op    (req_op),
        .o_sin       (sin),
        .i_sout      (sout),
        .o_rsp_valid (rsp_valid),
        .o_rsp_c     (rsp_c),
        .o_rsp_ctl   (rsp_ctl),
        .o_rsp_status(rsp_status)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // CRC4 as the remainder of polynomial long division by 10011
    function automatic logic [3:0] crc_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
        logic [71:0] m;
        logic [4:0]  rem;
        m   = {b, a, 1'b1, op, 4'b0000};
        rem = '0;
        for (int i = 71; i >= 0; i--) begin
            rem = {rem[3:0], m[i]};
            if (rem[4]) rem = rem ^ 5'b10011;
        end
        return rem[3:0];
    endfunction

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        case (op)
            OP_AND:  return b & a;
            OP_OR:   return b | a;
            OP_ADD:  return b + a;
            OP_SUB:  return b - a;
            default: return 32'h0;
        endcase
    endfunction

    task automatic send_frame(input bit typ, input logic [7:0] pay, input bit stop);
        bit bits[11];
        bits[0] = 1'b0;
        bits[1] = typ;
        for (int k = 0; k < 8; k++) bits[2 + k] = pay[7 - k];
        bits[10] = stop;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            sout = bits[i];
        end
    endtask

    // Issue a request from the current negedge; returns at the first TX cycle
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          output int waited);
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("ready_seen", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input int mode, input bit poke, input bit b2b);
        logic [7:0]  exp_bytes[9];
        bit          q[$];
        bit          cap[TX_LEN];
        logic [7:0]  cmd_cap;
        logic [31:0] exp_c;
        logic [7:0]  ctl;
        int          mism, busy, waited, cnt;

        for (int f = 0; f < 4; f++) exp_bytes[f]     = 8'(b >> (24 - 8 * f));
        for (int f = 0; f < 4; f++) exp_bytes[4 + f] = 8'(a >> (24 - 8 * f));
        exp_bytes[8] = {1'b1, op, crc_model(a, b, op)};
        for (int f = 0; f < 9; f++) begin
            q.push_back(1'b0);
            q.push_back(f == 8);
            for (int k = 7; k >= 0; k--) q.push_back(exp_bytes[f][k]);
            q.push_back(1'b1);
            if (f < 8) for (int g = 0; g < int'(GAP); g++) q.push_back(1'b1);
        end

        accept(a, b, op, waited);
        if (b2b) check("b2b_accept_wait", 64'(waited), 64'd1);
        check("sin_start", 64'(sin), 64'd0);
        check("valid_pulse_len", 64'(rsp_valid), 64'd0);
        if (have_last) check("rsp_c_hold", 64'(rsp_c), 64'(last_c));

        mism = 0; busy = 0;
        for (int i = 0; i < int'(TX_LEN); i++) begin
            if (i > 0) @(negedge clk);
            cap[i] = sin;
            if (sin !== q[i]) mism++;
            if (req_ready !== 1'b0) busy++;
            if (poke) begin
                req_valid = (i >= 10 && i < 20);
                req_a = $urandom; req_b = $urandom;
            end
        end
        for (int k = 0; k < 8; k++) cmd_cap[7 - k] = cap[128 + 2 + k];
        check("tx_stream", 64'(mism), 64'd0);
        check("busy_ready_low", 64'(busy), 64'd0);
        check("cmd_byte", 64'(cmd_cap), 64'(exp_bytes[8]));

        exp_c = alu_model(a, b, op);
        ctl   = {1'b0, 7'($urandom)};
        case (mode)
            MODE_OK: begin
                for (int f = 0; f < 4; f++) begin
                    send_frame(1'b0, 8'(exp_c >> (24 - 8 * f)), 1'b1);
                    @(negedge clk); sout = 1'b1;
                end
                send_frame(1'b1, ctl, 1'b1);
                @(negedge clk); sout = 1'b1;
                check("ok_valid", 64'(rsp_valid), 64'd1);
                check("ok_status", 64'(rsp_status), 64'd0);
                check("ok_c", 64'(rsp_c), 64'(exp_c));
                check("ok_ctl", 64'(rsp_ctl), 64'(ctl));
                last_c = exp_c; have_last = 1'b1;
            end
            MODE_ALU_ERR: begin
                send_frame(1'b1, 8'hC9, 1'b1);
                @(negedge clk); sout = 1'b1;
                check("err_valid", 64'(rsp_valid), 64'd1);
                check("err_status", 64'(rsp_status), 64'd1);
                check("err_ctl", 64'(rsp_ctl), 64'hC9);
                check("err_c", 64'(rsp_c), 64'd0);
                last_c = 32'h0; have_last = 1'b1;
            end
            MODE_TIMEOUT: begin
                cnt = 0;
                while (!rsp_valid && cnt < 200) begin
                    @(negedge clk);
                    cnt++;
                end
                check("tmo_latency_in_range", 64'(cnt >= 50 && cnt <= 51), 64'd1);
                check("tmo_status", 64'(rsp_status), 64'd2);
                have_last = 1'b0;
            end
            default: begin
                send_frame(1'b0, 8'(exp_c >> 24), 1'b1);
                send_frame(1'b0, 8'(exp_c >> 16), 1'b1);
                send_frame(1'b0, 8'(exp_c >> 8), 1'b0);
                @(negedge clk); sout = 1'b1;
                check("stop_valid", 64'(rsp_valid), 64'd1);
                check("stop_status", 64'(rsp_status), 64'd3);
                have_last = 1'b0;
            end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ops[4];
        int         waited, stray;
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB};
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; sout = 1'b1;
        last_c = 32'h0; have_last = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_sin", 64'(sin), 64'd1);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_c", 64'(rsp_c), 64'd0);
        check("rst_ctl", 64'(rsp_ctl), 64'd0);
        check("rst_status", 64'(rsp_status), 64'd0);

        run_txn(32'h33333333, 32'h33333333, OP_ADD, MODE_OK, 1'b0, 1'b0);
        check("add33_c", 64'(rsp_c), 64'h66666666);

        run_txn(32'h12121212, 32'h12121212, OP_AND, MODE_OK, 1'b0, 1'b1);
        check("and12_c", 64'(rsp_c), 64'h12121212);
        run_txn(32'h12121212, 32'h12121212, OP_OR, MODE_OK, 1'b0, 1'b1);
        check("or12_c", 64'(rsp_c), 64'h12121212);

        run_txn($urandom, $urandom, OP_SUB, MODE_ALU_ERR, 1'b0, 1'b1);
        run_txn($urandom, $urandom, OP_ADD, MODE_TIMEOUT, 1'b0, 1'b1);
        run_txn($urandom, $urandom, OP_OR, MODE_STOPERR, 1'b0, 1'b1);

        // Reset during frame 4 (A[31:24] = 0, so sin is low mid-payload)
        @(negedge clk);
        accept(32'h00000001, 32'h00000001, OP_ADD, waited);
        repeat (67) @(negedge clk);
        check("pre_rst_sin", 64'(sin), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_sin", 64'(sin), 64'd1);
        check("midrst_ready", 64'(req_ready), 64'd1);
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) stray++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (rsp_valid !== 1'b0) stray++;
        check("midrst_no_valid", 64'(stray), 64'd0);
        check("post_rst_ready", 64'(req_ready), 64'd1);
        check("post_rst_sin", 64'(sin), 64'd1);
        last_c = 32'h0; have_last = 1'b1;
        run_txn(32'h00000001, 32'h00000001, OP_ADD, MODE_OK, 1'b0, 1'b0);
        check("add_1_1_c", 64'(rsp_c), 64'h00000002);

        for (int t = 0; t < 6; t++) begin
            run_txn($urandom, $urandom, ops[$urandom_range(0, 3)], MODE_OK, 1'b1, 1'b1);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mtm_alu_ctrl.md
# mtm_alu_ctrl

Transaction controller that sequences the mtm_Alu serial interface. It accepts one parallel operation request (A, B, OP), generates the CRC4, serializes the nine request frames onto the ALU `sin` line, then deserializes the ALU response from `sout`. It returns result, control byte and status on a one-cycle valid pulse. It sits between a bus-side master and the mtm_Alu instance, on the same clock as the ALU.

## Interface
- `GAP_CYCLES`, default 5: idle-high cycles inserted after each transmitted stop bit (min 0).
- `RSP_TIMEOUT`, default 1000: maximum cycles spent waiting for a response start bit, per frame.
- `clk` in 1: system clock, shared with mtm_Alu.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle and able to accept a request.
- `req_a` in 32: operand A.
- `req_b` in 32: operand B.
- `req_op` in 3: ALU opcode; AND=000, OR=001, ADD=100, SUB=101.
- `sin` out 1: serial line to the mtm_Alu `sin`.
- `sout` in 1: serial line from the mtm_Alu `sout`.
- `rsp_valid` out 1: one-cycle pulse; the `rsp_*` outputs are valid.
- `rsp_c` out 32: result C.
- `rsp_ctl` out 8: received control byte.
- `rsp_status` out 2: 00 OK, 01 ALU error frame, 10 timeout, 11 framing error.

## Operation
- Frame format, both directions, 11 bits at one bit per clock:
  - start bit 0;
  - type bit (0 = data, 1 = cmd);
  - 8 payload bits, MSB first;
  - stop bit 1.
  - Line idles at 1.
- TX order: B[31:24], B[23:16], B[15:8], B[7:0], then A[31:24] down to A[7:0]. All eight are data frames. They are followed by one cmd frame with payload {1'b1, OP, CRC4}.
- CRC4:
  - Polynomial x^4+x+1, remainder initialised to 0.
  - Computed over the 72-bit message {B, A, 1'b1, OP, 4'b0000}, MSB first.
  - Per bit d: r <= {r[2], r[1], r[3]^r[0], r[3]^d}.
  - It may be computed serially during TX of the data frames, but must be final before the cmd frame.
- States:
  - IDLE: `req_ready`=1, `sin`=1. On `req_valid`&&`req_ready`, latch A/B/OP and go to TX.
  - TX: an 11-bit counter shifts out a frame, then GAP_CYCLES cycles of `sin`=1. Frame index runs 0..8. After the stop bit of frame 8, go to RX_HUNT immediately; the gap is not applied after the last frame.
  - RX_HUNT: wait for `sout`=0. On each entry a timeout counter is loaded with RSP_TIMEOUT. If it reaches 0, set status 10 and go to DONE.
  - RX_FRAME: sample the type, 8 payload bits and the stop bit on the 10 cycles after the start bit.
    - A stop bit of 0 gives status 11, then DONE.
    - Response frame 0 of type cmd: ALU error frame. `rsp_ctl` = payload, `rsp_c` = 0, status 01, then DONE.
    - Data frames 0..3 shift into C, MSB byte first. After each, return to RX_HUNT.
    - Frame 4 must be cmd. Its payload goes to `rsp_ctl`, status 00, then DONE.
    - A cmd frame at index 1..3, or a data frame at index 4, gives status 11, then DONE.
  - DONE: `rsp_valid`=1 for one cycle, then IDLE.
- The controller does not check the response CRC or flags; it passes the control byte through unchanged.

## Timing
- Reset values: `sin`=1, `req_ready`=1, `rsp_valid`=0, `rsp_c`=0, `rsp_ctl`=0, `rsp_status`=00.
- Request handshake: the request is accepted on the clock edge where `req_valid`&&`req_ready`. `req_ready` is 0 from the next cycle until the cycle after `rsp_valid`.
- `sin` drives the start bit of frame 0 in the cycle after acceptance.
- TX duration: 9×11 + 8×GAP_CYCLES cycles. This is 139 cycles at default.
- `rsp_valid` asserts in the cycle after the last sampled stop bit, or after timeout expiry.
- `rsp_*` outputs hold their value until the next `rsp_valid`.
- `req_valid` asserted while busy is ignored and not queued.
- Reset mid-operation:
  - All state returns to IDLE asynchronously.
  - `sin` goes to 1 immediately.
  - No `rsp_valid` pulse is produced.
- `sout` is sampled on the rising edge of `clk`. The ALU is synchronous, so no synchroniser is required.

## Test plan
- B=A=0x33333333, ADD:
  - `sin` carries 8 data frames of 0x33, then cmd 0xC0|CRC4, where CRC4 matches the bench model.
  - The ALU returns C=0x66666666, `rsp_status`=00, and `rsp_ctl` equals the ALU control byte.
- B=A=0x12121212, AND, then OR, back-to-back:
  - `rsp_c`=0x12121212 both times.
  - `req_ready` is low throughout each transaction.
  - The second `sin` start bit appears one cycle after the second accept.
- Bench drives `sout` with a single cmd frame of payload 0xC9 instead of the ALU → `rsp_status`=01, `rsp_ctl`=0xC9, `rsp_c`=0.
- `sout` held at 1 after TX with RSP_TIMEOUT=50 → `rsp_valid` with `rsp_status`=10 within 51 cycles of the last stop bit.
- Bench response with a stop bit of 0 in frame 2 → `rsp_status`=11.
- `rst_n` pulsed low during TX frame 4:
  - `sin`=1 at once and `req_ready`=1 after release.
  - A subsequent ADD 1+1 completes with C=0x00000002.
